// File: rtl/regfile_pkg.sv
// Shared defaults and the pending-write entry type for the register-file
// writeback arbiter.
package regfile_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 5;
    localparam int DEF_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] regno;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regwrite_arbiter_if.sv
// Two writeback requesters on one side, register-file write port and hazard
// mask on the other.
interface regwrite_arbiter_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_reg;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_reg;
    logic [DATA_W-1:0] req1_data;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [31:0]       busy_mask;

    modport master (
        output req0_valid, req0_reg, req0_data,
        output req1_valid, req1_reg, req1_data,
        input  req0_ready, req1_ready,
        input  regWrite, writeReg, writeData, busy_mask
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        input  req1_valid, req1_reg, req1_data,
        output req0_ready, req1_ready,
        output regWrite, writeReg, writeData, busy_mask
    );
endinterface

// File: rtl/regwrite_arbiter_wb_fifo.sv
// In-order pending-write FIFO; entry 0 is always the head, and per-entry
// valid bits let the parent build the hazard mask.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_reg,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [ADDR_W-1:0]             head_reg,
    output logic [DATA_W-1:0]             head_data,
    output logic                          full,
    output logic                          empty,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_reg,
    output logic [DEPTH-1:0]              ent_vld
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][ADDR_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [CW-1:0]                cnt_q, cnt_d;

    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign head_reg  = regs_q[0];
    assign head_data = data_q[0];
    assign ent_reg   = regs_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_vld[i] = (CW'(i) < cnt_q);
    end

    // Pop shifts toward the head first, so a same-edge push lands behind the
    // surviving entries and order is preserved.
    always_comb begin
        regs_d = regs_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (pop && !empty) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                regs_d[i] = regs_q[i+1];
                data_d[i] = data_q[i+1];
            end
            cnt_d = cnt_q - CW'(1);
        end
        if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == cnt_d) begin
                    regs_d[i] = push_reg;
                    data_d[i] = push_data;
                end
            end
            cnt_d = cnt_d + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/regwrite_arbiter.sv
// Round-robin arbiter merging ALU and load writebacks into one registered
// register-file write port, with a busy mask of all in-flight destinations.
module regwrite_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               clock_in,
    input  logic               reset_n,
    regwrite_arbiter_if.slave  bus
);
    logic [ADDR_W-1:0]                 head0_reg, head1_reg, sel_reg;
    logic [DATA_W-1:0]                 head0_data, head1_data, sel_data;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent0_reg, ent1_reg;
    logic [FIFO_DEPTH-1:0]             ent0_vld, ent1_vld;
    logic full0, full1, empty0, empty1;
    logic pop0, pop1, both;
    logic rr_last;
    logic              wr_q;
    logic [ADDR_W-1:0] wreg_q;
    logic [DATA_W-1:0] wdata_q;
    logic [31:0]       busy;

    function automatic logic [31:0] onehot(input logic [ADDR_W-1:0] r);
        onehot = 32'd1 << r;
    endfunction

    wb_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk(clock_in), .rst_n(reset_n),
        .push(bus.req0_valid && !full0), .push_reg(bus.req0_reg), .push_data(bus.req0_data),
        .pop(pop0), .head_reg(head0_reg), .head_data(head0_data),
        .full(full0), .empty(empty0), .ent_reg(ent0_reg), .ent_vld(ent0_vld)
    );

    wb_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk(clock_in), .rst_n(reset_n),
        .push(bus.req1_valid && !full1), .push_reg(bus.req1_reg), .push_data(bus.req1_data),
        .pop(pop1), .head_reg(head1_reg), .head_data(head1_data),
        .full(full1), .empty(empty1), .ent_reg(ent1_reg), .ent_vld(ent1_vld)
    );

    // rr_last=1 means requester 1 won the last tie, so requester 0 wins next.
    assign both     = !empty0 && !empty1;
    assign pop0     = !empty0 && (empty1 || rr_last);
    assign pop1     = !empty1 && (empty0 || !rr_last);
    assign sel_reg  = pop1 ? head1_reg  : head0_reg;
    assign sel_data = pop1 ? head1_data : head0_data;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            rr_last <= 1'b1;
        end else begin
            wr_q <= 1'b0;
            // A head targeting r0 still consumes its grant but never writes.
            if ((pop0 || pop1) && sel_reg != '0) begin
                wr_q    <= 1'b1;
                wreg_q  <= sel_reg;
                wdata_q <= sel_data;
            end
            if (both) rr_last <= pop1;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent0_vld[i]) busy = busy | onehot(ent0_reg[i]);
            if (ent1_vld[i]) busy = busy | onehot(ent1_reg[i]);
        end
        if (wr_q) busy = busy | onehot(wreg_q);
        busy[0] = 1'b0;
    end

    assign bus.req0_ready = !full0;
    assign bus.req1_ready = !full1;
    assign bus.regWrite   = wr_q;
    assign bus.writeReg   = wreg_q;
    assign bus.writeData  = wdata_q;
    assign bus.busy_mask  = busy;
endmodule
